// File: rtl/exu_wbu_buffer.sv
// Two-entry elastic buffer (head + skid) between execute and write-back.
// Optional synchronous flush port and logic enabled by defining EXWB_FLUSH_EN.
module exu_wbu_buffer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CADDR_W = 12
) (
  input  logic               clock,
  input  logic               reset,
`ifdef EXWB_FLUSH_EN
  input  logic               flush_i,
`endif
  input  logic               valid_pre_i,
  output logic               ready_pre_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic               wena_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]  csr_wdata_i,
  input  logic               csr_wena_i,
  input  logic [CADDR_W-1:0] csr_waddr_i,
  output logic               valid_post_o,
  input  logic               ready_post_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [DATA_W-1:0]  alu_result_o,
  output logic               wena_o,
  output logic [RADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0]  csr_wdata_o,
  output logic               csr_wena_o,
  output logic [CADDR_W-1:0] csr_waddr_o
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  alu;
    logic               wena;
    logic [RADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  csr_wdata;
    logic               csr_wena;
    logic [CADDR_W-1:0] csr_waddr;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t r_state;
  entry_t r_head;
  entry_t r_skid;
  logic   r_valid;
  logic   r_ready;

  entry_t w_in;
  logic   w_push;
  logic   w_pop;

  assign w_in = '{pc:        pc_i,
                  alu:       alu_result_i,
                  wena:      wena_i,
                  waddr:     waddr_i,
                  csr_wdata: csr_wdata_i,
                  csr_wena:  csr_wena_i,
                  csr_waddr: csr_waddr_i};

  // Handshake flags come from registers only, so ready_pre_o never depends on ready_post_i.
`ifdef EXWB_FLUSH_EN
  assign ready_pre_o = r_ready & ~flush_i;
`else
  assign ready_pre_o = r_ready;
`endif
  assign valid_post_o = r_valid;
  assign w_push       = valid_pre_i & ready_pre_o;
  assign w_pop        = r_valid & ready_post_i;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
`ifdef EXWB_FLUSH_EN
      if (flush_i) begin
        r_state <= EMPTY;
        r_head  <= '0;
        r_skid  <= '0;
        r_valid <= 1'b0;
        r_ready <= 1'b1;
      end else
`endif
      begin
        unique case (r_state)
          EMPTY: begin
            if (w_push) begin
              r_head  <= w_in;
              r_state <= ONE;
              r_valid <= 1'b1;
            end
          end
          ONE: begin
            if (w_push && w_pop) begin
              r_head <= w_in;
            end else if (w_push) begin
              r_skid  <= w_in;
              r_state <= FULL;
              r_ready <= 1'b0;
            end else if (w_pop) begin
              r_state <= EMPTY;
              r_valid <= 1'b0;
            end
          end
          FULL: begin
            if (w_pop) begin
              r_head  <= r_skid;
              r_state <= ONE;
              r_ready <= 1'b1;
            end
          end
          default: begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // Payload is masked while empty so write-back never sees a stale entry.
  assign pc_o         = r_valid ? r_head.pc        : '0;
  assign alu_result_o = r_valid ? r_head.alu       : '0;
  assign wena_o       = r_valid & r_head.wena;
  assign waddr_o      = r_valid ? r_head.waddr     : '0;
  assign csr_wdata_o  = r_valid ? r_head.csr_wdata : '0;
  assign csr_wena_o   = r_valid & r_head.csr_wena;
  assign csr_waddr_o  = r_valid ? r_head.csr_waddr : '0;

endmodule
